// File: rtl/pll_cmp_pkg.sv
// pll_cmp_pkg: shared codes and saturating arithmetic for the PLL frequency comparator
package pll_cmp_pkg;
  typedef enum logic [1:0] {
    ADJ_SLOWER = 2'b00,
    ADJ_HOLD   = 2'b01,
    ADJ_FASTER = 2'b11
  } adj_code_t;
  typedef enum logic [1:0] {EC_NONE, EC_SLOW, EC_MATCH, EC_FAST} edge_class_t;
  function automatic int sat_add(input int a, input int b, input int lo, input int hi);
    int s;
    s = a + b;
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/pll_freq_comparator_param_classifier.sv
// pll_edge_classifier: synchronises PLLClock and classifies each high-run as slow, matched or fast
module pll_edge_classifier
  import pll_cmp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 3,
  parameter int MATCH_RUN   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_pll,
  output edge_class_t o_class
);
  localparam logic [COUNT_W-1:0] MATCH_V = COUNT_W'(MATCH_RUN);
  logic [SYNC_STAGES-1:0] r_sync, r_fill;
  logic [COUNT_W-1:0] r_run;
  logic w_s, w_live, w_full;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_live = i_en && r_fill[SYNC_STAGES-1];
  assign w_full = &r_run;
  // Synchroniser keeps sampling while disabled; r_fill masks stages not yet loaded from PLLClock
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  // High-run length, saturating at all-ones, cleared by every low sample
  always_ff @(posedge i_clk)
    if (i_rst) r_run <= '0;
    else if (w_live) r_run <= !w_s ? '0 : w_full ? r_run : r_run + 1'b1;
  // A low sample closes the run; a saturated high run reports fast every cycle
  always_comb
    o_class = !w_live ? EC_NONE :
              w_s     ? (w_full ? EC_FAST : EC_NONE) :
              r_run < MATCH_V ? EC_SLOW : r_run == MATCH_V ? EC_MATCH : EC_FAST;
endmodule

// File: rtl/pll_freq_comparator_param.sv
// pll_freq_comparator_param: windowed slow/fast integration driving PLL adjust, error and lock outputs
module pll_freq_comparator_param
  import pll_cmp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 3,
  parameter int MATCH_RUN   = 1,
  parameter int WINDOW_LOG2 = 3,
  parameter int ACC_W       = 5,
  parameter int DEADBAND    = 1,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    PLLClock,
  output logic [1:0]              AdjustFreq,
  output logic                    DecisionValid,
  output logic signed [ACC_W-1:0] ErrorMag,
  output logic                    Locked
);
  localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;
  localparam int ACC_MIN = -(2 ** (ACC_W - 1));
  localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);
  edge_class_t w_class;
  adj_code_t r_adj, w_adj;
  logic signed [ACC_W-1:0] r_acc, r_err, w_acc_next;
  logic [WINDOW_LOG2-1:0] r_win;
  logic [LOCK_W-1:0] r_lock;
  logic r_valid, w_dec;
  int w_step;
  pll_edge_classifier #(
    .SYNC_STAGES(SYNC_STAGES),
    .COUNT_W    (COUNT_W),
    .MATCH_RUN  (MATCH_RUN)
  ) u_cls (
    .i_clk  (ClockIn),
    .i_rst  (Reset),
    .i_en   (Enable),
    .i_pll  (PLLClock),
    .o_class(w_class)
  );
  // This cycle's contribution folded into the accumulator, and the decision it would produce
  always_comb begin
    w_step     = w_class == EC_FAST ? 1 : w_class == EC_SLOW ? -1 : 0;
    w_acc_next = ACC_W'(sat_add(int'(r_acc), w_step, ACC_MIN, ACC_MAX));
    w_dec      = Enable && &r_win;
    w_adj      = int'(w_acc_next) < -DEADBAND ? ADJ_FASTER :
                 int'(w_acc_next) > DEADBAND  ? ADJ_SLOWER : ADJ_HOLD;
  end
  // Window integration; at the wrap the result is latched and the accumulator restarts from zero
  always_ff @(posedge ClockIn)
    if (Reset) begin
      r_acc   <= '0;
      r_win   <= '0;
      r_lock  <= '0;
      r_adj   <= ADJ_HOLD;
      r_err   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_dec;
      if (Enable) begin
        r_win <= r_win + 1'b1;
        r_acc <= w_dec ? '0 : w_acc_next;
      end
      if (w_dec) begin
        r_adj  <= w_adj;
        r_err  <= w_acc_next;
        r_lock <= w_adj != ADJ_HOLD ? '0 : r_lock == LOCK_W'(LOCK_COUNT) ? r_lock : r_lock + 1'b1;
      end
    end
  assign AdjustFreq    = r_adj;
  assign DecisionValid = r_valid;
  assign ErrorMag      = r_err;
  assign Locked        = r_lock == LOCK_W'(LOCK_COUNT);
endmodule

// File: tb/tb_pll_freq_comparator_param.sv
// tb_pll_freq_comparator_param: directed scoreboard bench for the windowed PLL frequency comparator
module tb_pll_freq_comparator_param;
  logic clk = 0, rst = 1, en = 1, pll = 0;
  logic [1:0] adj, adj2;
  logic dv, dv2, lk, lk2;
  logic signed [4:0] err;
  logic signed [3:0] err2;
  typedef struct {
    logic [1:0] adj;
    int         err;
    logic       lk;
    int         at;
  } exp_t;
  exp_t q[$], q2[$];
  exp_t e, e2;
  int checks = 0, errors = 0, ecount = 0, mode = 0;
  bit chk2 = 0;

  pll_freq_comparator_param dut (
    .ClockIn(clk), .Reset(rst), .Enable(en), .PLLClock(pll),
    .AdjustFreq(adj), .DecisionValid(dv), .ErrorMag(err), .Locked(lk)
  );
  pll_freq_comparator_param #(.ACC_W(4), .WINDOW_LOG2(4)) dut2 (
    .ClockIn(clk), .Reset(rst), .Enable(en), .PLLClock(pll),
    .AdjustFreq(adj2), .DecisionValid(dv2), .ErrorMag(err2), .Locked(lk2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

  function automatic logic pat(input int m, input int k);
    return m == 0 ? 1'b0 :
           m == 1 ? logic'(k % 2 == 1) :
           m == 2 ? (k <= 32 ? logic'(k % 2 == 1) : logic'(k % 4 != 0)) : 1'b1;
  endfunction

  always @(negedge clk) pll = pat(mode, ecount + 1);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic push(input int at, input logic [1:0] a, input int ev, input logic l);
    q.push_back('{a, ev, l, at});
  endtask

  task automatic push2(input int at, input logic [1:0] a, input int ev, input logic l);
    q2.push_back('{a, ev, l, at});
  endtask

  always @(negedge clk)
    if (dv) begin
      if (q.size() == 0) chk("dut unexpected decision edge", ecount, -1);
      else begin
        e = q.pop_front();
        chk("dut decision edge", ecount, e.at);
        chk("dut AdjustFreq", int'(adj), int'(e.adj));
        chk("dut ErrorMag", int'(err), e.err);
        chk("dut Locked", int'(lk), int'(e.lk));
      end
    end

  always @(negedge clk)
    if (dv2 && chk2) begin
      if (q2.size() == 0) chk("dut2 unexpected decision edge", ecount, -1);
      else begin
        e2 = q2.pop_front();
        chk("dut2 decision edge", ecount, e2.at);
        chk("dut2 AdjustFreq", int'(adj2), int'(e2.adj));
        chk("dut2 ErrorMag", int'(err2), e2.err);
        chk("dut2 Locked", int'(lk2), int'(e2.lk));
      end
    end

  task automatic do_reset(input int m);
    @(negedge clk);
    mode = m;
    rst  = 1;
    en   = 1;
    repeat (2) @(negedge clk);
    chk("reset AdjustFreq", int'(adj), 1);
    chk("reset ErrorMag", int'(err), 0);
    chk("reset Locked", int'(lk), 0);
    chk("reset DecisionValid", int'(dv), 0);
    rst = 0;
  endtask

  initial begin
    do_reset(0);
    push(8, 2'b11, -6, 0);
    push(16, 2'b11, -8, 0);
    push(24, 2'b11, -8, 0);
    repeat (25) @(negedge clk);

    do_reset(2);
    push(8, 2'b01, 0, 0);
    push(16, 2'b01, 0, 0);
    push(24, 2'b01, 0, 0);
    push(32, 2'b01, 0, 1);
    push(40, 2'b01, 1, 1);
    push(48, 2'b00, 2, 0);
    push(56, 2'b00, 2, 0);
    repeat (57) @(negedge clk);

    do_reset(3);
    chk2 = 1;
    push(8, 2'b01, 0, 0);
    push(16, 2'b00, 7, 0);
    push(24, 2'b00, 8, 0);
    push(32, 2'b00, 8, 0);
    push2(16, 2'b00, 7, 0);
    push2(32, 2'b00, 7, 0);
    repeat (33) @(negedge clk);
    chk2 = 0;

    do_reset(0);
    push(8, 2'b11, -6, 0);
    push(21, 2'b11, -8, 0);
    push(29, 2'b11, -8, 0);
    repeat (10) @(negedge clk);
    en = 0;
    repeat (5) @(negedge clk);
    en = 1;
    repeat (15) @(negedge clk);

    do_reset(1);
    push(8, 2'b01, 0, 0);
    push(16, 2'b01, 0, 0);
    push(24, 2'b01, 0, 0);
    push(32, 2'b01, 0, 1);
    repeat (36) @(negedge clk);
    chk("Locked before mid-window reset", int'(lk), 1);
    rst = 1;
    @(negedge clk);
    chk("mid reset AdjustFreq", int'(adj), 1);
    chk("mid reset ErrorMag", int'(err), 0);
    chk("mid reset Locked", int'(lk), 0);
    chk("mid reset DecisionValid", int'(dv), 0);
    rst = 0;
    push(8, 2'b01, 0, 0);
    push(16, 2'b01, 0, 0);
    repeat (17) @(negedge clk);

    chk("dut pending decisions", q.size(), 0);
    chk("dut2 pending decisions", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_freq_comparator_param.md
Name: pll_freq_comparator_param

Overview:
- Parametrised successor of the codebase's PLL frequency comparator.
- Samples the PLL output on rising ClockIn edges and measures each PLLClock high-run length.
- Classifies each run as slow, matched or fast and integrates the results in a signed saturating accumulator over a configurable window.
- At each window end, issues an AdjustFreq decision, an error magnitude, a valid strobe and a lock indicator to the PLL loop-filter/DCO control.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on PLLClock (min 2).
- COUNT_W, 3: high-run counter width; RUN_MAX = 2^COUNT_W-1.
- MATCH_RUN, 1: run length treated as matched (1 ≤ MATCH_RUN < RUN_MAX).
- WINDOW_LOG2, 3: decision window = 2^WINDOW_LOG2 enabled cycles.
- ACC_W, 5: signed accumulator width.
- DEADBAND, 1: |acc| ≤ DEADBAND gives the hold decision (DEADBAND < 2^(ACC_W-1)-1).
- LOCK_COUNT, 4: consecutive hold decisions required to assert Locked.

Ports:
- ClockIn, input, 1: sole clock; all logic on the rising edge.
- Reset, input, 1: synchronous, active-high.
- Enable, input, 1: counting enable.
- PLLClock, input, 1: PLL output, asynchronous; sampled through the synchroniser.
- AdjustFreq, output, 2: 00 = slow PLL down, 01 = no change, 11 = speed PLL up.
- DecisionValid, output, 1: one-cycle pulse when AdjustFreq/ErrorMag update.
- ErrorMag, output, ACC_W: signed accumulator snapshot at the last decision.
- Locked, output, 1: high after LOCK_COUNT consecutive 01 decisions.

Behaviour:
- Reset (sampled on a ClockIn edge, any time, including mid-window):
  - Clears synchroniser, run counter, accumulator, window counter and lock counter.
  - Output values: AdjustFreq=01, DecisionValid=0, ErrorMag=0, Locked=0.
  - Reset dominates Enable.
- Sampling: s = last synchroniser stage. PLLClock affects classification SYNC_STAGES cycles later.
- Run counter (Enable=1):
  - s=1 and run<RUN_MAX: run+1, no event.
  - s=1 and run==RUN_MAX: hold at RUN_MAX, event FAST every cycle (stuck-high detection).
  - s=0: classify run, then clear run. Classification: run<MATCH_RUN gives SLOW; run==MATCH_RUN gives MATCH; run>MATCH_RUN gives FAST.
  - Consequence: every low sample after another low sample is SLOW (run=0).
- Accumulator:
  - Contributions: FAST = +1, SLOW = -1, MATCH or no event = 0.
  - Saturates at +2^(ACC_W-1)-1 and -2^(ACC_W-1); never wraps.
- Window counter: WINDOW_LOG2 bits, increments each enabled cycle, wraps naturally.
- Decision (on the enabled cycle where the window counter wraps to 0):
  - acc_next = accumulator including this cycle's contribution.
  - acc_next < -DEADBAND gives AdjustFreq=11; acc_next > DEADBAND gives AdjustFreq=00; otherwise 01.
  - ErrorMag = acc_next. DecisionValid=1 for that cycle only.
  - Accumulator reloads 0 on the same edge; nothing is carried into the next window.
  - Outputs are registered: visible the cycle after the deciding edge and held until the next decision.
- Lock:
  - A 01 decision increments the lock counter, saturating at LOCK_COUNT.
  - Locked=1 when the counter equals LOCK_COUNT.
  - Any 00/11 decision clears the counter and deasserts Locked on the same update.
- Enable=0:
  - Synchroniser keeps sampling.
  - Run, accumulator, window and lock counters freeze.
  - Outputs hold; DecisionValid=0.
  - Resuming continues the partial window.

Decomposition:
- Package pll_cmp_pkg:
  - adj_code_t: ADJ_SLOWER=2'b00, ADJ_HOLD=2'b01, ADJ_FASTER=2'b11.
  - edge_class_t: EC_NONE, EC_SLOW, EC_MATCH, EC_FAST.
  - Saturating add helper function.
- Sub-module pll_edge_classifier: synchroniser plus run counter, emitting one edge_class_t per cycle.
- Top level: accumulator, window counter, decision logic and lock logic.

Test Plan (defaults: 8-cycle window, acc range -16..+15):
- PLLClock held 0, Enable=1 from reset → first decision AdjustFreq=11, ErrorMag = -(8-SYNC_STAGES) = -6; every later decision ErrorMag=-8, Locked=0.
- PLLClock toggles 1,0 each ClockIn cycle → every decision AdjustFreq=01, ErrorMag=0; Locked rises with the 4th decision.
- PLLClock pattern 1,1,1,0 repeating → from the second window on, ErrorMag=+2 and AdjustFreq=00; Locked (if set) clears at that decision.
- PLLClock held 1 → run saturates at 7, then +1 per cycle → ErrorMag=+8 and AdjustFreq=00 once fully saturated. With ACC_W=4 and WINDOW_LOG2=4, ErrorMag clamps at +7 (no wrap).
- Enable low for 5 cycles mid-window with PLLClock held 0 → decision delayed 5 cycles, ErrorMag still -8, no DecisionValid while Enable=0.
- Reset asserted mid-window after Locked=1 → next cycle AdjustFreq=01, ErrorMag=0, Locked=0; first post-reset decision occurs 8 enabled cycles later.
